neuron_writeback: RTL and testbench
===================================

# neuron_writeback

Downstream stage of the MAC core in the neural accelerator. It captures each finished neuron's accumulator value, rescales it, applies the layer's activation and saturates the result to the neuron word width. It then writes the result into the neuron dual-port RAM at consecutive addresses from a per-layer write base. It counts neurons written and raises a one-cycle layer-done pulse, which the control unit uses to advance to the next layer.

## Interface
Parameters:
- DATA_W, 8: neuron word width (RAM data width)
- ACC_W, 16: MAC accumulator width (signed)
- ADDR_W, 8: neuron RAM address width
- FRAC_SHIFT, 4: arithmetic right shift applied to the accumulator before saturation

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a layer (accepted only in IDLE)
- write_base  in  ADDR_W  first write address of the layer, latched on start
- neuron_count  in  ADDR_W  neurons in the layer, latched on start
- act_sel  in  1  0 = ReLU, 1 = identity; latched on start
- acc_in  in  ACC_W  signed accumulator value of the finished neuron
- acc_valid  in  1  acc_in valid this cycle (delayed neuron-finished strobe)
- ram_wre  out  1  neuron RAM write enable
- ram_waddr  out  ADDR_W  neuron RAM write address
- ram_wdata  out  DATA_W  neuron RAM write data (signed)
- busy  out  1  high in RUN and DRAIN
- layer_done  out  1  one-cycle pulse after the layer's last write
- spurious  out  1  sticky: acc_valid seen outside RUN; cleared by reset or an accepted start

## Operation
- State machine: IDLE, RUN, DRAIN, DONE.
  - IDLE:
    - start with neuron_count != 0 latches base, count and act_sel, clears the index and spurious, and moves to RUN.
    - start with neuron_count == 0 latches the same values and moves to DONE; no writes are issued.
  - RUN: each acc_valid is accepted and enters the pipeline with address write_base + index. The index then increments. Acceptance at index == count-1 moves to DRAIN.
  - DRAIN: waits until both pipeline stages are empty, then moves to DONE.
  - DONE: layer_done = 1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. The latched parameters are unaffected.
- acc_valid in IDLE, DRAIN or DONE is dropped (no write) and sets spurious.
- Address arithmetic is modulo 2^ADDR_W: base 0xFE with count 4 writes 0xFE, 0xFF, 0x00, 0x01.
- Data path, per accepted value:
  - s = acc_in >>> FRAC_SHIFT (sign-preserving).
  - Saturate s to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - ReLU: if the saturated value < 0, output 0. Identity: output the saturated value unchanged.
- Neuron ordering equals arrival order. No reordering and no buffering beyond the pipeline.

## Timing
- Two-stage pipeline.
  - Stage 1 registers the shifted and saturated value plus its address.
  - Stage 2 registers the activation result into ram_wdata/ram_waddr and sets ram_wre.
- acc_valid accepted in cycle N gives ram_wre = 1 during cycle N+2, one cycle wide.
- Back-to-back acc_valid is sustained at one write per cycle.
- The last accepted value in cycle N gives ram_wre in N+2 and layer_done in N+3. busy drops in the layer_done cycle.
- With neuron_count == 0: start in cycle N gives layer_done in N+1.
- Reset values: ram_wre = 0, ram_waddr = 0, ram_wdata = 0, busy = 0, layer_done = 0, spurious = 0. State is IDLE, the index is 0 and both pipeline valid bits are 0.
- Reset mid-layer: the pipeline is flushed and in-flight values are never written. ram_wre = 0 from the cycle after the reset edge. No layer_done is generated.
- start and the final acc_valid cannot coincide, because start is ignored in RUN.

## Structure
- Shared package (accelerator package) holds:
  - state encoding for IDLE/RUN/DRAIN/DONE;
  - ACT_RELU = 1'b0 and ACT_IDENTITY = 1'b1;
  - default DATA_W, ACC_W, ADDR_W and FRAC_SHIFT.
- One sub-module: activation_unit. It is purely combinational (shift, saturate, activation select), is parameterised by ACC_W, DATA_W and FRAC_SHIFT, and is instantiated between stage 1 and stage 2.
- The FSM, index counter and pipeline registers stay in neuron_writeback.

## Test plan
- ReLU scaling: base 10, count 1, acc_in 0x0350 → ram_waddr 10, ram_wdata 0x35, ram_wre in cycle N+2, layer_done in N+3.
- Saturation:
  - Identity, count 3, acc_in 0x7FFF, 0x8000, 0xFFF0 → writes 0x7F, 0x80, 0xFF.
  - ReLU with the same inputs → 0x7F, 0x00, 0x00.
- Streaming and wrap: base 0xFE, count 4, acc_valid on 4 consecutive cycles → four consecutive ram_wre cycles at addresses 0xFE, 0xFF, 0x00, 0x01, then one layer_done.
- Zero count: start with neuron_count 0 → no ram_wre, layer_done in the next cycle, busy stays 0.
- Protocol errors:
  - acc_valid while IDLE → no write, spurious = 1; the next accepted start clears it.
  - start during RUN → ignored, and the layer finishes with the original count.
- Reset mid-layer: count 4; assert reset the cycle after the 2nd acc_valid → only the 1st write appears, outputs return to 0, no layer_done, and a new start works normally.

Source files
------------

// File: rtl/neuron_writeback_pkg.sv
// Shared definitions for the neuron write-back stage: FSM encoding,
// activation selectors and default datapath widths.
package neuron_writeback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

  localparam logic ACT_RELU     = 1'b0;
  localparam logic ACT_IDENTITY = 1'b1;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ACC_W      = 16;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_FRAC_SHIFT = 4;

endpackage

// File: rtl/neuron_writeback_if.sv
// Bundle between the MAC/control side (master) and the write-back stage (slave),
// including the neuron RAM write port and status outputs.
interface neuron_writeback_if import neuron_writeback_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic                     start;
  logic [ADDR_W-1:0]        write_base;
  logic [ADDR_W-1:0]        neuron_count;
  logic                     act_sel;
  logic signed [ACC_W-1:0]  acc_in;
  logic                     acc_valid;
  logic                     ram_wre;
  logic [ADDR_W-1:0]        ram_waddr;
  logic signed [DATA_W-1:0] ram_wdata;
  logic                     busy;
  logic                     layer_done;
  logic                     spurious;

  modport master (
    output start, write_base, neuron_count, act_sel, acc_in, acc_valid,
    input  ram_wre, ram_waddr, ram_wdata, busy, layer_done, spurious
  );

  modport slave (
    input  start, write_base, neuron_count, act_sel, acc_in, acc_valid,
    output ram_wre, ram_waddr, ram_wdata, busy, layer_done, spurious
  );

endinterface

// File: rtl/neuron_writeback_activation_unit.sv
// Combinational rescale/saturate of the raw accumulator (feeds stage 1) and
// activation select on the registered saturated value (feeds stage 2).
module activation_unit import neuron_writeback_pkg::*; #(
  parameter int ACC_W      = DEF_ACC_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] sat_o,
  input  logic signed [DATA_W-1:0] sat_i,
  input  logic                     act_sel_i,
  output logic signed [DATA_W-1:0] act_o
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 <<< (DATA_W - 1)));

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc_i >>> FRAC_SHIFT;
    if (shifted > SAT_MAX) begin
      sat_o = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_o = SAT_MIN[DATA_W-1:0];
    end else begin
      sat_o = shifted[DATA_W-1:0];
    end
  end

  always_comb begin
    if (act_sel_i == ACT_RELU && sat_i[DATA_W-1]) begin
      act_o = '0;
    end else begin
      act_o = sat_i;
    end
  end

endmodule

// File: rtl/neuron_writeback.sv
// Captures finished neuron accumulators, rescales/activates them through a
// two-stage pipeline and writes them to consecutive neuron RAM addresses.
module neuron_writeback import neuron_writeback_pkg::*; #(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT
) (
  input logic               clk,
  input logic               reset,
  neuron_writeback_if.slave bus
);

  wb_state_e                state_q;
  logic [ADDR_W-1:0]        base_q;
  logic [ADDR_W-1:0]        count_q;
  logic [ADDR_W-1:0]        idx_q;
  logic                     act_q;
  logic                     spurious_q;
  logic                     busy_q;
  logic                     layer_done_q;

  logic                     s1_vld_q;
  logic signed [DATA_W-1:0] s1_data_q;
  logic [ADDR_W-1:0]        s1_addr_q;
  logic                     ram_wre_q;
  logic [ADDR_W-1:0]        ram_waddr_q;
  logic signed [DATA_W-1:0] ram_wdata_q;

  logic                     accept_d;
  logic [ADDR_W-1:0]        s1_addr_d;
  logic signed [DATA_W-1:0] sat_d;
  logic signed [DATA_W-1:0] act_d;

  assign accept_d  = (state_q == ST_RUN) && bus.acc_valid;
  assign s1_addr_d = base_q + idx_q;

  activation_unit #(
    .ACC_W      (ACC_W),
    .DATA_W     (DATA_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_act (
    .acc_i     (bus.acc_in),
    .sat_o     (sat_d),
    .sat_i     (s1_data_q),
    .act_sel_i (act_q),
    .act_o     (act_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      act_q        <= ACT_RELU;
      spurious_q   <= 1'b0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      layer_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            base_q     <= bus.write_base;
            count_q    <= bus.neuron_count;
            act_q      <= bus.act_sel;
            idx_q      <= '0;
            spurious_q <= 1'b0;
            if (bus.neuron_count != '0) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else begin
              state_q      <= ST_DONE;
              layer_done_q <= 1'b1;
            end
          end
          if (bus.acc_valid) spurious_q <= 1'b1;
        end
        ST_RUN: begin
          if (accept_d) begin
            idx_q <= idx_q + ADDR_W'(1);
            if (idx_q == count_q - ADDR_W'(1)) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bus.acc_valid) spurious_q <= 1'b1;
          // Leave once stage 1 is empty: the stage-2 write retires on this same
          // edge, so layer_done lands the cycle after the final ram_wre.
          if (!s1_vld_q) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.acc_valid) spurious_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q    <= 1'b0;
      s1_data_q   <= '0;
      s1_addr_q   <= '0;
      ram_wre_q   <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
    end else begin
      s1_vld_q  <= accept_d;
      ram_wre_q <= s1_vld_q;
      if (accept_d) begin
        s1_data_q <= sat_d;
        s1_addr_q <= s1_addr_d;
      end
      if (s1_vld_q) begin
        ram_waddr_q <= s1_addr_q;
        ram_wdata_q <= act_d;
      end
    end
  end

  assign bus.ram_wre    = ram_wre_q;
  assign bus.ram_waddr  = ram_waddr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.busy       = busy_q;
  assign bus.layer_done = layer_done_q;
  assign bus.spurious   = spurious_q;

endmodule

// File: tb/tb_neuron_writeback.sv
// Scoreboard bench for neuron_writeback: directed layers push expected writes
// and layer_done events; a negedge monitor pops and checks them with cycle stamps.
module tb_neuron_writeback;
  import neuron_writeback_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    bit         is_done;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sbq[$];

  neuron_writeback_if #(.DATA_W(8), .ACC_W(16), .ADDR_W(8)) bus ();

  neuron_writeback #(
    .DATA_W(8), .ACC_W(16), .ADDR_W(8), .FRAC_SHIFT(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic start_layer(input logic [7:0] base, input logic [7:0] count, input logic act);
    bus.start        = 1'b1;
    bus.write_base   = base;
    bus.neuron_count = count;
    bus.act_sel      = act;
    if (count == 8'd0) sbq.push_back('{1'b1, 8'h00, 8'h00, cyc + 1});
    tick(1);
    bus.start = 1'b0;
  endtask

  // push=0 sends a value that must never reach the RAM (flushed by reset)
  task automatic send(input logic [15:0] acc, input logic [7:0] addr, input logic [7:0] data,
                      input bit last, input bit push);
    bus.acc_valid = 1'b1;
    bus.acc_in    = acc;
    if (push) sbq.push_back('{1'b0, addr, data, cyc + 2});
    if (last) sbq.push_back('{1'b1, 8'h00, 8'h00, cyc + 3});
    tick(1);
    bus.acc_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.ram_wre === 1'b1 || bus.layer_done === 1'b1) begin
      tests++;
      if (bus.ram_wre === 1'b1 && bus.layer_done === 1'b1) begin
        fails++;
        $display("FAIL overlap: ram_wre and layer_done both high at cycle %0d", cyc);
      end else if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected: wre=%0b done=%0b addr=0x%0h data=0x%0h at cycle %0d, none expected",
                 bus.ram_wre, bus.layer_done, bus.ram_waddr, bus.ram_wdata, cyc);
      end else begin
        e = sbq.pop_front();
        if (e.is_done) begin
          if (bus.layer_done !== 1'b1 || cyc != e.cyc) begin
            fails++;
            $display("FAIL layer_done: got wre=%0b done=%0b at cycle %0d, expected done at cycle %0d",
                     bus.ram_wre, bus.layer_done, cyc, e.cyc);
          end
        end else if (bus.ram_wre !== 1'b1 || cyc != e.cyc ||
                     bus.ram_waddr !== e.addr || bus.ram_wdata !== e.data) begin
          fails++;
          $display("FAIL write: got wre=%0b addr=0x%0h data=0x%0h cycle %0d, expected addr=0x%0h data=0x%0h cycle %0d",
                   bus.ram_wre, bus.ram_waddr, bus.ram_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.write_base   = '0;
    bus.neuron_count = '0;
    bus.act_sel      = ACT_RELU;
    bus.acc_in       = '0;
    bus.acc_valid    = 1'b0;
    tick(2);
    check("rst_wre",      {7'd0, bus.ram_wre},    8'h00);
    check("rst_waddr",    bus.ram_waddr,          8'h00);
    check("rst_wdata",    bus.ram_wdata,          8'h00);
    check("rst_busy",     {7'd0, bus.busy},       8'h00);
    check("rst_done",     {7'd0, bus.layer_done}, 8'h00);
    check("rst_spurious", {7'd0, bus.spurious},   8'h00);
    reset = 1'b0;
    tick(1);

    // ReLU scaling, single neuron
    start_layer(8'd10, 8'd1, ACT_RELU);
    check("busy_run", {7'd0, bus.busy}, 8'h01);
    send(16'h0350, 8'd10, 8'h35, 1'b1, 1'b1);
    tick(4);
    check("busy_after", {7'd0, bus.busy}, 8'h00);

    // Saturation, identity then ReLU
    start_layer(8'h20, 8'd3, ACT_IDENTITY);
    send(16'h7FFF, 8'h20, 8'h7F, 1'b0, 1'b1);
    send(16'h8000, 8'h21, 8'h80, 1'b0, 1'b1);
    send(16'hFFF0, 8'h22, 8'hFF, 1'b1, 1'b1);
    tick(4);
    start_layer(8'h30, 8'd3, ACT_RELU);
    send(16'h7FFF, 8'h30, 8'h7F, 1'b0, 1'b1);
    send(16'h8000, 8'h31, 8'h00, 1'b0, 1'b1);
    send(16'hFFF0, 8'h32, 8'h00, 1'b1, 1'b1);
    tick(4);

    // Streaming with address wrap
    start_layer(8'hFE, 8'd4, ACT_IDENTITY);
    send(16'h0010, 8'hFE, 8'h01, 1'b0, 1'b1);
    send(16'h0020, 8'hFF, 8'h02, 1'b0, 1'b1);
    send(16'h0030, 8'h00, 8'h03, 1'b0, 1'b1);
    send(16'hFFE0, 8'h01, 8'hFE, 1'b1, 1'b1);
    tick(4);

    // Zero-count layer
    start_layer(8'h40, 8'd0, ACT_RELU);
    check("zero_busy", {7'd0, bus.busy}, 8'h00);
    tick(3);

    // Spurious acc_valid while idle, cleared by next start
    send(16'h0100, 8'h00, 8'h00, 1'b0, 1'b0);
    check("spurious_set", {7'd0, bus.spurious}, 8'h01);
    tick(2);
    start_layer(8'h50, 8'd1, ACT_RELU);
    check("spurious_clr", {7'd0, bus.spurious}, 8'h00);
    send(16'h0100, 8'h50, 8'h10, 1'b1, 1'b1);
    tick(4);

    // start during RUN is ignored
    start_layer(8'h60, 8'd2, ACT_IDENTITY);
    send(16'h0020, 8'h60, 8'h02, 1'b0, 1'b1);
    bus.start        = 1'b1;
    bus.write_base   = 8'h90;
    bus.neuron_count = 8'd5;
    tick(1);
    bus.start = 1'b0;
    send(16'h0040, 8'h61, 8'h04, 1'b1, 1'b1);
    tick(4);
    check("ign_busy", {7'd0, bus.busy}, 8'h00);

    // Reset mid-layer: second value must be flushed
    start_layer(8'h70, 8'd4, ACT_IDENTITY);
    send(16'h0050, 8'h70, 8'h05, 1'b0, 1'b1);
    send(16'h0060, 8'h71, 8'h06, 1'b0, 1'b0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_wre",   {7'd0, bus.ram_wre}, 8'h00);
    check("mid_waddr", bus.ram_waddr,       8'h00);
    check("mid_wdata", bus.ram_wdata,       8'h00);
    check("mid_busy",  {7'd0, bus.busy},    8'h00);
    tick(5);
    start_layer(8'h80, 8'd1, ACT_RELU);
    send(16'h0123, 8'h80, 8'h12, 1'b1, 1'b1);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick(1);
    tick(3);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected events never seen, expected 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
